// File: rtl/pci_pkg.sv
// Shared PCI definitions: arbiter state encoding, bus command codes and
// the default unused-grant timeout.
package pci_pkg;

  // Arbiter states. DEAD is the all-grants-high turnaround cycle between
  // two different owners.
  typedef enum logic [1:0] {
    ST_DEAD   = 2'd0,
    ST_PARK   = 2'd1,
    ST_GRANT  = 2'd2,
    ST_ACTIVE = 2'd3
  } arb_state_e;

  // C/BE# command encodings used by the initiators on the shared bus.
  localparam logic [3:0] CMD_READ  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0011;

  // Idle-bus clocks a granted master may waste before losing the grant.
  localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/pci_rr_pick.sv
// Rotating-priority picker: returns the first asserted request found when
// searching upward from ptr_i, wrapping modulo N. Purely combinational.
module pci_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] winner_o,
  output logic          any_o
);

  logic [IW-1:0] idx;

  // Walk the N candidates starting at ptr_i; the first hit wins.
  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no path leaves one unassigned, which would infer a latch.
    winner_o = '0;
    any_o    = 1'b0;
    idx      = ptr_i;
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
      idx = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: one GNT# at a time, round-robin priority, bus
// parking, hidden arbitration and an unused-grant timeout. FRAME#/IRDY# are
// only observed.
module pci_arbiter
  import pci_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int PARK    = 0,
  parameter  int TIMEOUT = int'(TIMEOUT_DEFAULT),
  localparam int OW      = $clog2(NREQ),
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_n,
  input  logic            frame_n,
  input  logic            irdy_n,
  output logic [NREQ-1:0] gnt_n,
  output logic [OW-1:0]   owner,
  output logic            owner_valid
);

  localparam logic [NREQ-1:0] ONE           = NREQ'(1);
  localparam logic [OW-1:0]   PARK_IDX      = OW'(PARK);
  localparam logic [OW-1:0]   PARK_PTR_NEXT = OW'((PARK + 1) % NREQ);
  localparam logic [CW-1:0]   TIMEOUT_CNT   = CW'(TIMEOUT);

  arb_state_e      state_q;
  logic [NREQ-1:0] gnt_n_q;
  logic [OW-1:0]   owner_q;
  logic            owner_valid_q;
  logic [OW-1:0]   ptr_q;
  logic [CW-1:0]   idle_cnt_q;
  logic [CW-1:0]   idle_cnt_d;
  logic            idle_q;     // bus was idle on the previous edge
  logic            to_mask_q;  // previous owner timed out; skip it once

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] pick_req;
  logic [OW-1:0]   win;
  logic [OW-1:0]   ptr_next;
  logic            any_req;
  logic            other_req;
  logic            owner_req;
  logic            bus_idle;
  logic            frame_fall;

  assign req        = ~req_n;
  assign owner_oh   = ONE << owner_q;
  assign other_req  = |(req & ~owner_oh);
  assign owner_req  = req[owner_q];
  assign bus_idle   = frame_n & irdy_n;
  assign frame_fall = idle_q & ~frame_n;
  assign idle_cnt_d = (idle_cnt_q == TIMEOUT_CNT) ? idle_cnt_q : idle_cnt_q + CW'(1);
  assign ptr_next   = (win == OW'(NREQ - 1)) ? '0 : win + OW'(1);

  // A master that just timed out is hidden from the picker for the one DEAD
  // cycle that follows its revocation.
  assign pick_req = req & ~(to_mask_q ? owner_oh : '0);

  pci_rr_pick #(.N(NREQ)) u_pick (
    .req_i    (pick_req),
    .ptr_i    (ptr_q),
    .winner_o (win),
    .any_o    (any_req)
  );

  assign gnt_n       = gnt_n_q;
  assign owner       = owner_q;
  assign owner_valid = owner_valid_q;

  // Arbiter FSM with registered grant outputs; reset drops every grant at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_DEAD;
      gnt_n_q       <= '1;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      ptr_q         <= '0;
      idle_cnt_q    <= '0;
      idle_q        <= 1'b1;
      to_mask_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
      idle_q    <= bus_idle;
      to_mask_q <= 1'b0;
      case (state_q)
        ST_DEAD: begin
          owner_valid_q <= 1'b1;
          if (any_req) begin
            state_q    <= ST_GRANT;
            gnt_n_q    <= ~(ONE << win);
            owner_q    <= win;
            ptr_q      <= ptr_next;
            idle_cnt_q <= '0;
          end else begin
            state_q <= ST_PARK;
            gnt_n_q <= ~(ONE << PARK_IDX);
            owner_q <= PARK_IDX;
          end
        end
        ST_PARK: begin
          if (other_req) begin
            state_q       <= ST_DEAD;
            gnt_n_q       <= '1;
            owner_valid_q <= 1'b0;
          end else if (owner_req) begin
            // Parked master asks for the bus: keep its grant, no dead cycle.
            state_q    <= ST_GRANT;
            ptr_q      <= PARK_PTR_NEXT;
            idle_cnt_q <= '0;
          end
        end
        ST_GRANT: begin
          if (frame_fall) begin
            state_q <= ST_ACTIVE;
          end else if (!owner_req) begin
            state_q       <= ST_DEAD;
            gnt_n_q       <= '1;
            owner_valid_q <= 1'b0;
          end else if (bus_idle) begin
            idle_cnt_q <= idle_cnt_d;
            if (idle_cnt_d == TIMEOUT_CNT) begin
              state_q       <= ST_DEAD;
              gnt_n_q       <= '1;
              owner_valid_q <= 1'b0;
              to_mask_q     <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          // Another request revokes the grant at once; the running
          // transaction finishes on its own (hidden arbitration).
          if (other_req || (bus_idle && !owner_req)) begin
            state_q       <= ST_DEAD;
            gnt_n_q       <= '1;
            owner_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_DEAD;
          gnt_n_q       <= '1;
          owner_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_arbiter.sv
// Scoreboard bench for pci_arbiter (NREQ=4, PARK=0, TIMEOUT=16). Stimulus
// drives on the falling edge and queues the hand-computed outputs expected
// after the next rising edge; a monitor pops and compares 1 time unit after
// every rising edge and also checks grant exclusivity on every edge.
module tb_pci_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_n = 4'b1111;
  logic       frame_n = 1'b1;
  logic       irdy_n = 1'b1;
  logic [3:0] gnt_n;
  logic [1:0] owner;
  logic       owner_valid;

  typedef struct {
    logic [3:0] gnt_n;
    logic [1:0] owner;
    logic       valid;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pci_arbiter #(.NREQ(4), .PARK(0), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_n       (req_n),
    .frame_n     (frame_n),
    .irdy_n      (irdy_n),
    .gnt_n       (gnt_n),
    .owner       (owner),
    .owner_valid (owner_valid)
  );

  // Values are packed as {gnt_n, owner_valid, owner}.
  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {gnt_n,valid,owner}=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] r, input logic f, input logic i,
                      input logic [3:0] eg, input logic [1:0] eo, input logic ev,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst     = 1'b1;
    req_n   = r;
    frame_n = f;
    irdy_n  = i;
    e.gnt_n = eg;
    e.owner = eo;
    e.valid = ev;
    e.name  = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: exclusivity every edge, scoreboard compare when an entry is due.
  initial begin : monitor
    exp_t e;
    int   lows;
    logic ok;
    forever begin
      @(posedge clk);
      #1;
      lows = 4 - $countones(gnt_n);
      ok   = (lows <= 1) && (owner_valid == (lows == 1));
      check("one_grant", {6'd0, ok}, 7'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, {gnt_n, owner_valid, owner}, {e.gnt_n, e.valid, e.owner});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] oh_cur;
    logic [3:0] oh_nxt;

    // Reset held: all grants high, owner 0.
    repeat (2) @(negedge clk);
    #1;
    check("reset_values", {gnt_n, owner_valid, owner}, {4'b1111, 1'b0, 2'd0});

    // Release with no requests: park on master 0.
    step(4'b1111, 1, 1, 4'b1110, 2'd0, 1, "park");
    step(4'b1111, 1, 1, 4'b1110, 2'd0, 1, "park_hold");

    // Masters 1 and 3 request: DEAD, then master 1 (ptr 0).
    step(4'b0101, 1, 1, 4'b1111, 2'd0, 0, "park_to_dead");
    step(4'b0101, 1, 1, 4'b1101, 2'd1, 1, "grant_m1");
    step(4'b0101, 1, 1, 4'b1101, 2'd1, 1, "m1_hold");
    step(4'b0111, 1, 1, 4'b1111, 2'd1, 0, "m1_drop_dead");
    step(4'b0111, 1, 1, 4'b0111, 2'd3, 1, "grant_m3");

    // Back to park, then parked master requests: no dead cycle.
    step(4'b1111, 1, 1, 4'b1111, 2'd3, 0, "m3_drop_dead");
    step(4'b1111, 1, 1, 4'b1110, 2'd0, 1, "repark");
    step(4'b1110, 1, 1, 4'b1110, 2'd0, 1, "park_self_grant");

    // Master 0 active, master 3 raises: hidden arbitration.
    step(4'b1110, 0, 0, 4'b1110, 2'd0, 1, "m0_active");
    step(4'b0110, 0, 0, 4'b1111, 2'd0, 0, "m3_raise_revoke");
    step(4'b0110, 0, 0, 4'b0111, 2'd3, 1, "grant_m3_hidden");
    step(4'b0110, 1, 0, 4'b0111, 2'd3, 1, "m3_wait_busy");
    step(4'b1110, 1, 1, 4'b1111, 2'd3, 0, "m3_drop");
    step(4'b1110, 1, 1, 4'b1110, 2'd0, 1, "grant_m0");
    step(4'b1011, 1, 1, 4'b1111, 2'd0, 0, "m0_drop");
    step(4'b1011, 1, 1, 4'b1011, 2'd2, 1, "grant_m2");

    // Everyone requests; master 2 leaves the bus idle for 16 clocks.
    for (int k = 1; k <= 15; k++)
      step(4'b0000, 1, 1, 4'b1011, 2'd2, 1, "timeout_wait");
    step(4'b0000, 1, 1, 4'b1111, 2'd2, 0, "timeout_revoke");
    step(4'b0000, 1, 1, 4'b0111, 2'd3, 1, "after_to_m3");
    step(4'b1000, 1, 1, 4'b1111, 2'd3, 0, "m3_done");
    step(4'b1000, 1, 1, 4'b1110, 2'd0, 1, "after_to_m0");
    step(4'b1001, 1, 1, 4'b1111, 2'd0, 0, "m0_done");
    step(4'b1001, 1, 1, 4'b1101, 2'd1, 1, "after_to_m1");
    step(4'b1011, 1, 1, 4'b1111, 2'd1, 0, "m1_done");
    step(4'b1011, 1, 1, 4'b1011, 2'd2, 1, "m2_regrant");
    step(4'b1011, 0, 0, 4'b1011, 2'd2, 1, "m2_active");

    // Asynchronous reset mid-transaction while gnt_n=1011.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_async", {gnt_n, owner_valid, owner}, {4'b1111, 1'b0, 2'd0});

    // Release with all requesting: ptr is back at 0, so master 0 wins.
    step(4'b0000, 1, 1, 4'b1110, 2'd0, 1, "rst_release_ptr0");

    // Continuous requests, 2-clock transactions: rotation 0,1,2,3,0.
    for (int k = 0; k < 4; k++) begin
      oh_cur = 4'b0001 << k;
      oh_nxt = 4'b0001 << ((k + 1) % 4);
      step(4'b0000, 0, 0, ~oh_cur, 2'(k), 1, "rot_active");
      step(4'b0000, 1, 0, 4'b1111, 2'(k), 0, "rot_revoke");
      step(4'b0000, 1, 1, ~oh_nxt, 2'((k + 1) % 4), 1, "rot_grant");
    end

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
